image_rle_encoder: RTL and testbench

IMAGE_RLE_ENCODER -- requirements
Module: image_rle_encoder

---
 rtl/image_rle_encoder.sv | 146 ++++++++++++++
 tb/tb_image_rle_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_rle_encoder.sv
// Raster-order run-length encoder: turns a stream of RGB444 pixels into
// {start, end, colour, last} runs over the linear pixel index of one frame.
module image_rle_encoder #(
  parameter int IMG_W = 584,
  parameter int IMG_H = 167,
  parameter int IDX_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_color,
  output logic             run_valid,
  input  logic             run_ready,
  output logic [IDX_W-1:0] run_start,
  output logic [IDX_W-1:0] run_end,
  output logic [11:0]      run_color,
  output logic             run_last
);

  localparam int               TOTAL    = IMG_W * IMG_H;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] open_start;
  logic [11:0]      open_color;
  logic [11:0]      pend_color;

  logic             slot_free, xfer, at_last, same_color;
  logic             slot_load, open_load, pend_load;
  logic [IDX_W-1:0] slot_start_n, slot_end_n;
  logic [11:0]      slot_color_n;
  logic             slot_last_n;

  // The slot counts as free when it is empty or being drained this cycle, so
  // a pixel that closes a run is only accepted when its run has somewhere to go.
  assign slot_free  = !run_valid || run_ready;
  assign in_ready   = (state != FLUSH) && slot_free;
  assign xfer       = in_valid && in_ready;
  assign at_last    = (idx == LAST_IDX);
  assign same_color = (in_color == open_color);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next   = state;
    slot_load    = 1'b0;
    open_load    = 1'b0;
    pend_load    = 1'b0;
    slot_start_n = open_start;
    slot_end_n   = idx - IDX_W'(1);
    slot_color_n = open_color;
    slot_last_n  = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          if (at_last) begin
            // Single-pixel frame: the run opens and closes on the same pixel.
            slot_load    = 1'b1;
            slot_start_n = idx;
            slot_end_n   = idx;
            slot_color_n = in_color;
            slot_last_n  = 1'b1;
          end else begin
            open_load  = 1'b1;
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (at_last && same_color) begin
            slot_load   = 1'b1;
            slot_end_n  = LAST_IDX;
            slot_last_n = 1'b1;
            state_next  = IDLE;
          end else if (at_last) begin
            // Two runs close at once; the final one-pixel run waits in FLUSH.
            slot_load  = 1'b1;
            pend_load  = 1'b1;
            state_next = FLUSH;
          end else if (!same_color) begin
            slot_load = 1'b1;
            open_load = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          slot_load    = 1'b1;
          slot_start_n = LAST_IDX;
          slot_end_n   = LAST_IDX;
          slot_color_n = pend_color;
          slot_last_n  = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      open_start <= '0;
      open_color <= '0;
      pend_color <= '0;
      run_valid  <= 1'b0;
      run_start  <= '0;
      run_end    <= '0;
      run_color  <= '0;
      run_last   <= 1'b0;
    end else begin
      state <= state_next;

      if (xfer)
        idx <= at_last ? '0 : idx + IDX_W'(1);

      if (open_load) begin
        open_start <= idx;
        open_color <= in_color;
      end

      if (pend_load)
        pend_color <= in_color;

      if (slot_load) begin
        run_valid <= 1'b1;
        run_start <= slot_start_n;
        run_end   <= slot_end_n;
        run_color <= slot_color_n;
        run_last  <= slot_last_n;
      end else if (run_ready) begin
        run_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_rle_encoder.sv
// Directed bench for image_rle_encoder: a 4x2 instance for per-pixel vectors,
// back-pressure, reset and random frames; a 6x4 instance for a boxed image.
module tb_image_rle_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4x2 instance
  logic        a_in_valid, a_in_ready, a_run_valid, a_run_ready, a_run_last;
  logic [11:0] a_in_color, a_run_color;
  logic [2:0]  a_run_start, a_run_end;

  // 6x4 instance
  logic        b_in_valid, b_in_ready, b_run_valid, b_run_ready, b_run_last;
  logic [11:0] b_in_color, b_run_color;
  logic [4:0]  b_run_start, b_run_end;

  image_rle_encoder #(.IMG_W(4), .IMG_H(2), .IDX_W(3)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_color(a_in_color),
    .run_valid(a_run_valid), .run_ready(a_run_ready),
    .run_start(a_run_start), .run_end(a_run_end),
    .run_color(a_run_color), .run_last(a_run_last)
  );

  image_rle_encoder #(.IMG_W(6), .IMG_H(4), .IDX_W(5)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_color(b_in_color),
    .run_valid(b_run_valid), .run_ready(b_run_ready),
    .run_start(b_run_start), .run_end(b_run_end),
    .run_color(b_run_color), .run_last(b_run_last)
  );

  typedef struct packed {
    logic [7:0]  s;
    logic [7:0]  e;
    logic [11:0] c;
    logic        l;
  } run_t;

  typedef struct {
    logic [11:0] color;
    logic        exp_valid;
    logic [2:0]  exp_start;
    logic [2:0]  exp_end;
    logic [11:0] exp_color;
    logic        exp_last;
  } vec_t;

  run_t a_q[$];
  run_t b_q[$];
  int   errors = 0;
  int   checks = 0;

  // Run collectors: record every completed run handshake.
  always @(posedge clk) begin
    if (!reset && a_run_valid && a_run_ready)
      a_q.push_back('{s: 8'(a_run_start), e: 8'(a_run_end), c: a_run_color, l: a_run_last});
    if (!reset && b_run_valid && b_run_ready)
      b_q.push_back('{s: 8'(b_run_start), e: 8'(b_run_end), c: b_run_color, l: b_run_last});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [11:0] c, input bit rand_rr);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_color = c;
    #1;
    while (!a_in_ready && n < 100) begin
      @(posedge clk); #1;
      if (rand_rr) a_run_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    check("send_a ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    if (rand_rr) a_run_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_b(input logic [11:0] c);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_color = c;
    #1;
    while (!b_in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("send_b ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_a(input int n, input string name);
    int k = 0;
    while (a_q.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " run count"}, a_q.size(), n);
  endtask

  task automatic check_run_a(input string name, input int idx, input run_t exp);
    if (idx < a_q.size()) begin
      check({name, " start"}, a_q[idx].s, exp.s);
      check({name, " end"},   a_q[idx].e, exp.e);
      check({name, " color"}, a_q[idx].c, exp.c);
      check({name, " last"},  a_q[idx].l, exp.l);
    end else begin
      check({name, " present"}, 0, 1);
    end
  endtask

  vec_t        vecs[16];
  logic [11:0] px[16];
  run_t        exp_q[$];
  run_t        b_exp[5];
  int          base;
  int          start;

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_color = '0; a_run_ready = 1'b1;
    b_in_valid = 1'b0; b_in_color = '0; b_run_ready = 1'b1;

    // Pixel vectors: an all-0x0F0 frame, then colours 1,1,1,1,1,1,1,2.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{color: 12'h0F0, exp_valid: (i == 7), exp_start: 3'd0,
                  exp_end: 3'd7, exp_color: 12'h0F0, exp_last: 1'b1};
    for (int i = 8; i < 16; i++)
      vecs[i] = '{color: (i == 15) ? 12'h002 : 12'h001, exp_valid: (i == 15),
                  exp_start: 3'd0, exp_end: 3'd6, exp_color: 12'h001, exp_last: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst run_valid", a_run_valid, 0);
    check("rst run_start", a_run_start, 0);
    check("rst run_end",   a_run_end, 0);
    check("rst run_color", a_run_color, 0);
    check("rst run_last",  a_run_last, 0);
    reset = 1'b0;
    #1;
    check("rst a in_ready", a_in_ready, 1);
    check("rst b in_ready", b_in_ready, 1);

    // Table-driven per-pixel vectors with run_ready held high
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1'b1;
      a_in_color = vecs[i].color;
      check($sformatf("vec%0d in_ready", i), a_in_ready, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d run_valid", i), a_run_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d start", i), a_run_start, vecs[i].exp_start);
        check($sformatf("vec%0d end", i),   a_run_end,   vecs[i].exp_end);
        check($sformatf("vec%0d color", i), a_run_color, vecs[i].exp_color);
        check($sformatf("vec%0d last", i),  a_run_last,  vecs[i].exp_last);
      end
    end
    a_in_valid = 1'b0;

    // Final single-pixel run out of FLUSH
    check("flush in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    check("flush run_valid", a_run_valid, 1);
    check("flush start", a_run_start, 7);
    check("flush end",   a_run_end, 7);
    check("flush color", a_run_color, 12'h002);
    check("flush last",  a_run_last, 1);
    check("post-flush in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    check("run_valid drops", a_run_valid, 0);

    // Alternating colours with a 5-cycle consumer stall after the first run
    base = a_q.size();
    send_a(12'h001, 1'b0);
    send_a(12'h002, 1'b0);
    a_run_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_color  = 12'h001;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall in_ready",  a_in_ready, 0);
      check("stall run_valid", a_run_valid, 1);
      check("stall start", a_run_start, 0);
      check("stall end",   a_run_end, 0);
      check("stall color", a_run_color, 12'h001);
      @(posedge clk); #1;
    end
    a_run_ready = 1'b1;
    for (int p = 2; p < 8; p++)
      send_a((p % 2 == 0) ? 12'h001 : 12'h002, 1'b0);
    wait_a(base + 8, "alt");
    for (int k = 0; k < 8; k++)
      check_run_a($sformatf("alt%0d", k), base + k,
                  '{s: 8'(k), e: 8'(k), c: (k % 2 == 0) ? 12'h001 : 12'h002, l: (k == 7)});

    // Reset mid-frame with an open run and a loaded, unconsumed slot
    a_run_ready = 1'b0;
    for (int p = 0; p < 4; p++) send_a(12'h004, 1'b0);
    send_a(12'h009, 1'b0);
    check("pre-reset slot held", a_run_valid, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid rst run_valid", a_run_valid, 0);
    check("mid rst run_start", a_run_start, 0);
    check("mid rst run_color", a_run_color, 0);
    check("mid rst in_ready",  a_in_ready, 1);
    base = a_q.size();
    a_run_ready = 1'b1;
    for (int p = 0; p < 8; p++) send_a(12'h123, 1'b0);
    wait_a(base + 1, "post-reset");
    repeat (5) @(posedge clk);
    #1;
    check("post-reset no extra runs", a_q.size(), base + 1);
    check_run_a("post-reset run", base, '{s: 8'd0, e: 8'd7, c: 12'h123, l: 1'b1});

    // Two back-to-back random frames with random back-pressure
    for (int i = 0; i < 16; i++) px[i] = 12'($urandom_range(0, 2));
    for (int f = 0; f < 2; f++) begin
      start = 0;
      for (int p = 0; p < 8; p++)
        if (p == 7 || px[f*8 + p + 1] != px[f*8 + p]) begin
          exp_q.push_back('{s: 8'(start), e: 8'(p), c: px[f*8 + p], l: (p == 7)});
          start = p + 1;
        end
    end
    base = a_q.size();
    for (int i = 0; i < 16; i++) send_a(px[i], 1'b1);
    a_run_ready = 1'b1;
    wait_a(base + exp_q.size(), "rand");
    repeat (5) @(posedge clk);
    #1;
    check("rand no extra runs", a_q.size(), base + exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check_run_a($sformatf("rand%0d", k), base + k, exp_q[k]);

    // 6x4 image: rows 0-1 black, rows 2-3 cols 2-3 white, rest black
    b_exp[0] = '{s: 8'd0,  e: 8'd13, c: 12'h000, l: 1'b0};
    b_exp[1] = '{s: 8'd14, e: 8'd15, c: 12'hFFF, l: 1'b0};
    b_exp[2] = '{s: 8'd16, e: 8'd19, c: 12'h000, l: 1'b0};
    b_exp[3] = '{s: 8'd20, e: 8'd21, c: 12'hFFF, l: 1'b0};
    b_exp[4] = '{s: 8'd22, e: 8'd23, c: 12'h000, l: 1'b1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        send_b((r >= 2 && c >= 2 && c <= 3) ? 12'hFFF : 12'h000);
    repeat (5) @(posedge clk);
    #1;
    check("box run count", b_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < b_q.size()) begin
        check($sformatf("box%0d start", k), b_q[k].s, b_exp[k].s);
        check($sformatf("box%0d end", k),   b_q[k].e, b_exp[k].e);
        check($sformatf("box%0d color", k), b_q[k].c, b_exp[k].c);
        check($sformatf("box%0d last", k),  b_q[k].l, b_exp[k].l);
      end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
